intr_ctrl: RTL

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_if.sv | 20 ++
 rtl/intr_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/intr_ctrl_if.sv
// Host-side register bus for intr_ctrl: active-low strobes, byte address,
// 32-bit write data and combinational read data.
interface intr_ctrl_if;
  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (
    output CS_N, RD_N, WR_N, Addr, DataIn,
    input  DataOut
  );

  modport slave (
    input  CS_N, RD_N, WR_N, Addr, DataIn,
    output DataOut
  );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronised active-low sources captured into sticky
// pending bits (level or falling-edge), masked priority vector and a registered IRQ_N.
module intr_ctrl #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            reset,
  intr_ctrl_if.slave      bus,
  input  logic [NSRC-1:0] SRC_N,
  output logic            IRQ_N
);
  localparam logic [11:0] ADDR_PEND = 12'h000;
  localparam logic [11:0] ADDR_MASK = 12'h004;
  localparam logic [11:0] ADDR_ACK  = 12'h008;
  localparam logic [11:0] ADDR_VEC  = 12'h00C;
  localparam logic [11:0] ADDR_CTRL = 12'h010;
  localparam logic [11:0] ADDR_MODE = 12'h014;

  logic [NSRC-1:0] sync1_r;
  logic [NSRC-1:0] sync2_r;
  logic [NSRC-1:0] prev_r;
  logic [NSRC-1:0] pend_r;
  logic [NSRC-1:0] mask_r;
  logic [NSRC-1:0] mode_r;
  logic            gie_r;
  logic            irq_n_r;

  logic            wr_s;
  logic            rd_s;
  logic [NSRC-1:0] set_s;
  logic [NSRC-1:0] ack_s;
  logic [NSRC-1:0] enabled_s;
  logic [2:0]      vec_idx_s;
  logic [31:0]     vec_s;
  logic [31:0]     rdata_s;

  assign wr_s = ~bus.CS_N & ~bus.WR_N;
  assign rd_s = ~bus.CS_N & ~bus.RD_N;

  // Level sources set while low; edge sources only on a high-to-low step of the synced input.
  assign set_s     = ~sync2_r & (~mode_r | prev_r);
  assign enabled_s = pend_r & mask_r;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= {NSRC{1'b1}};
      sync2_r <= {NSRC{1'b1}};
      prev_r  <= {NSRC{1'b1}};
    end else begin
      sync1_r <= SRC_N;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  always_comb begin
    ack_s = {NSRC{1'b0}};
    if (wr_s && (bus.Addr == ADDR_ACK)) begin
      ack_s = bus.DataIn[NSRC-1:0];
    end else begin
      ack_s = {NSRC{1'b0}};
    end
  end

  // Software-writable configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r <= {NSRC{1'b0}};
      mode_r <= {NSRC{1'b0}};
      gie_r  <= 1'b0;
    end else if (wr_s) begin
      case (bus.Addr)
        ADDR_MASK: mask_r <= bus.DataIn[NSRC-1:0];
        ADDR_MODE: mode_r <= bus.DataIn[NSRC-1:0];
        ADDR_CTRL: gie_r  <= bus.DataIn[0];
        default: begin
        end
      endcase
    end else begin
      mask_r <= mask_r;
      mode_r <= mode_r;
      gie_r  <= gie_r;
    end
  end

  // Sticky pending bits; a set on the same edge as an ACK wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r  <= {NSRC{1'b0}};
      irq_n_r <= 1'b1;
    end else begin
      pend_r  <= (pend_r & ~ack_s) | set_s;
      irq_n_r <= ~(gie_r & (|enabled_s));
    end
  end

  assign IRQ_N = irq_n_r;

  // Descending scan so the lowest enabled index is the one left standing.
  always_comb begin
    vec_idx_s = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      vec_idx_s = enabled_s[i] ? 3'(i) : vec_idx_s;
    end
    vec_s = {(|enabled_s), 28'd0, vec_idx_s};
  end

  always_comb begin
    rdata_s = 32'd0;
    case (bus.Addr)
      ADDR_PEND: rdata_s = 32'(pend_r);
      ADDR_MASK: rdata_s = 32'(mask_r);
      ADDR_VEC:  rdata_s = vec_s;
      ADDR_CTRL: rdata_s = {31'd0, gie_r};
      ADDR_MODE: rdata_s = 32'(mode_r);
      default:   rdata_s = 32'd0;
    endcase
  end

  assign bus.DataOut = rd_s ? rdata_s : 32'd0;
endmodule
